// File: rtl/fade_pkg.sv
// Purpose: shared types and constants for the fade PWM modulator slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FADE_LEVEL_W default width, FSM state enum, PHASE_MAX (last phase index).
package fade_pkg;

  localparam int FADE_LEVEL_W = 8;

  // Last phase index of a PWM period for a given level width (period = 2**w-1 ticks).
  function automatic int fade_phase_max(input int w);
    return (2 ** w) - 2;
  endfunction

  localparam int PHASE_MAX = fade_phase_max(FADE_LEVEL_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } fade_state_e;

endpackage

// File: rtl/fade_gamma_curve.sv
// Purpose: square-law level->duty map, duty(L) = (L*L + 2**W-1) >> W.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of i_level.
// Ports:
//   i_level  in   LEVEL_W  requested brightness
//   o_duty   out  LEVEL_W  perceptual duty; duty(0)=0, duty(max)=max, monotonic
module fade_gamma_curve #(
  parameter int LEVEL_W = 8
) (
  input  logic [LEVEL_W-1:0] i_level,
  output logic [LEVEL_W-1:0] o_duty
);

  logic [2*LEVEL_W-1:0] w_sq;
  logic [2*LEVEL_W-1:0] w_sum;

  assign w_sq  = {{LEVEL_W{1'b0}}, i_level} * {{LEVEL_W{1'b0}}, i_level};
  // The rounding term lifts every nonzero level to at least 1 and maps max to max;
  // the sum never exceeds 2**(2W) - 2**W, so it cannot overflow the product width.
  assign w_sum = w_sq + {{LEVEL_W{1'b0}}, {LEVEL_W{1'b1}}};
  assign o_duty = LEVEL_W'(w_sum >> LEVEL_W);

endmodule

// File: rtl/fade_pwm_modulator.sv
// Purpose: turns fade_level/direction into a glitch-free PWM with period-boundary duty latch.
// Latency: pwm_out valid one cycle after LOAD; pulses/duty are registered (1 cycle).
// Backpressure: none; en low lets the current period finish before returning to IDLE.
// Optional feature: FADE_PWM_GAMMA_EN selects the square-law duty curve (default linear).
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_en              run request (level)
//   i_fade_level      requested brightness
//   i_direction       fade direction (0 brightening, 1 dimming)
//   o_pwm_out         registered PWM output
//   o_period_start    one-cycle pulse when a new duty is latched
//   o_duty_applied    duty currently in force
//   o_peak_pulse      one-cycle pulse on direction 0->1
//   o_trough_pulse    one-cycle pulse on direction 1->0
//   o_busy            high whenever the FSM is not IDLE
module fade_pwm_modulator
  import fade_pkg::*;
#(
  parameter int LEVEL_W  = FADE_LEVEL_W,
  parameter int PRESCALE = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic [LEVEL_W-1:0] i_fade_level,
  input  logic               i_direction,
  output logic               o_pwm_out,
  output logic               o_period_start,
  output logic [LEVEL_W-1:0] o_duty_applied,
  output logic               o_peak_pulse,
  output logic               o_trough_pulse,
  output logic               o_busy
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  // The package constant already covers the default width.
  localparam int PHASE_LAST_I = (LEVEL_W == FADE_LEVEL_W) ? PHASE_MAX : fade_phase_max(LEVEL_W);
  localparam logic [LEVEL_W-1:0] PHASE_LAST = LEVEL_W'(PHASE_LAST_I);
  localparam logic [PS_W-1:0]    PS_LAST    = PS_W'(PRESCALE - 1);

  fade_state_e        r_state;
  fade_state_e        w_state_nxt;
  logic [PS_W-1:0]    r_prescaler;
  logic [LEVEL_W-1:0] r_phase;
  logic [LEVEL_W-1:0] r_duty;
  logic               r_pwm;
  logic               r_period_start;
  logic               r_dir_d;
  logic               r_peak;
  logic               r_trough;

  logic               w_tick;
  logic               w_active;
  logic               w_period_end;
  logic [LEVEL_W-1:0] w_duty;

`ifdef FADE_PWM_GAMMA_EN
  fade_gamma_curve #(
    .LEVEL_W (LEVEL_W)
  ) u_gamma (
    .i_level (i_fade_level),
    .o_duty  (w_duty)
  );
`else
  assign w_duty = i_fade_level;
`endif

  assign w_tick       = (r_prescaler == PS_LAST);
  assign w_active     = (r_state == RUN) || (r_state == DRAIN);
  assign w_period_end = w_active && w_tick && (r_phase == PHASE_LAST);

  // ---------------------------------------------------------------- state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_en) w_state_nxt = LOAD;
      LOAD:    w_state_nxt = RUN;
      RUN:     if (!i_en) w_state_nxt = DRAIN;
      // Re-asserting en cancels the drain; otherwise stop at the period boundary.
      DRAIN: begin
        if (i_en) begin
          w_state_nxt = RUN;
        end else if (w_period_end) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- state outputs
  always_comb begin
    o_busy = 1'b0;
    if (r_state != IDLE) begin
      o_busy = 1'b1;
    end
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prescaler    <= '0;
      r_phase        <= '0;
      r_duty         <= '0;
      r_pwm          <= 1'b0;
      r_period_start <= 1'b0;
      r_dir_d        <= 1'b0;
      r_peak         <= 1'b0;
      r_trough       <= 1'b0;
    end else begin
      // Direction edge detect runs regardless of en or state.
      r_dir_d  <= i_direction;
      r_peak   <= i_direction & ~r_dir_d;
      r_trough <= ~i_direction & r_dir_d;

      r_period_start <= 1'b0;
      // Compare against the duty in force for the whole period; max duty exceeds
      // every phase, so the output never dips across a wrap.
      r_pwm <= w_active && (r_phase < r_duty);

      case (r_state)
        LOAD: begin
          r_duty         <= w_duty;
          r_phase        <= '0;
          r_prescaler    <= '0;
          r_period_start <= 1'b1;
        end
        RUN, DRAIN: begin
          if (w_tick) begin
            r_prescaler <= '0;
            if (r_phase == PHASE_LAST) begin
              r_phase <= '0;
              // Only latch a new duty when another period will actually run.
              if (w_state_nxt != IDLE) begin
                r_duty         <= w_duty;
                r_period_start <= 1'b1;
              end
            end else begin
              r_phase <= r_phase + LEVEL_W'(1);
            end
          end else begin
            r_prescaler <= r_prescaler + PS_W'(1);
          end
        end
        default: begin
          r_prescaler <= '0;
          r_phase     <= '0;
        end
      endcase
    end
  end

  assign o_pwm_out      = r_pwm;
  assign o_period_start = r_period_start;
  assign o_duty_applied = r_duty;
  assign o_peak_pulse   = r_peak;
  assign o_trough_pulse = r_trough;

endmodule

// File: tb/tb_fade_pwm_modulator.sv
// Purpose: self-checking bench for fade_pwm_modulator (LEVEL_W=8, PRESCALE=1, period 255 clocks).
// Latency: n/a.
// Backpressure: n/a.
module tb_fade_pwm_modulator;

  localparam int LW  = 8;
  localparam int PER = 255;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic          dir = 1'b0;
  logic [LW-1:0] lvl = '0;

  logic          pwm_out;
  logic          period_start;
  logic [LW-1:0] duty_applied;
  logic          peak_pulse;
  logic          trough_pulse;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fade_pwm_modulator #(
    .LEVEL_W  (LW),
    .PRESCALE (1)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_en           (en),
    .i_fade_level   (lvl),
    .i_direction    (dir),
    .o_pwm_out      (pwm_out),
    .o_period_start (period_start),
    .o_duty_applied (duty_applied),
    .o_peak_pulse   (peak_pulse),
    .o_trough_pulse (trough_pulse),
    .o_busy         (busy)
  );

  function automatic int ref_duty(input int l);
`ifdef FADE_PWM_GAMMA_EN
    return (l * l + 255) >> 8;
`else
    return l;
`endif
  endfunction

  // Reference model: mode 0 idle, 1 loading, 2 running; m_pos = ticks into the period.
  int m_mode = 0;
  bit m_drain = 0;
  int m_pos = 0;
  int m_duty = 0;
  bit m_dir = 0;
  bit e_pwm = 0, e_ps = 0, e_peak = 0, e_trough = 0, e_busy = 0;

  task automatic model_step();
    bit last;
    if (rst) begin
      m_mode = 0; m_drain = 0; m_pos = 0; m_duty = 0; m_dir = 0;
      e_pwm = 0; e_ps = 0; e_peak = 0; e_trough = 0;
    end else begin
      e_peak   = dir && !m_dir;
      e_trough = !dir && m_dir;
      m_dir    = dir;
      e_ps     = 0;
      case (m_mode)
        0: begin
          e_pwm = 0;
          if (en) m_mode = 1;
        end
        1: begin
          m_duty = ref_duty(int'(lvl)); m_pos = 0; e_ps = 1; e_pwm = 0;
          m_mode = 2; m_drain = 0;
        end
        default: begin
          last  = (m_pos == PER - 1);
          e_pwm = (m_pos < m_duty);
          if (m_drain && !en && last) begin
            m_mode = 0; m_pos = 0; m_drain = 0;
          end else begin
            m_drain = !en;
            if (last) begin
              m_pos = 0; m_duty = ref_duty(int'(lvl)); e_ps = 1;
            end else begin
              m_pos++;
            end
          end
        end
      endcase
    end
    e_busy = (m_mode != 0);
  endtask

  // One clock: inputs held since the previous falling edge were sampled at the
  // rising edge; observe at the falling edge and advance the model with them.
  task automatic cyc();
    @(negedge clk);
    model_step();
  endtask

  task automatic wait_ps(output bit ok);
    ok = 0;
    for (int i = 0; i < 600; i++) begin
      if (period_start === 1'b1) begin
        ok = 1;
        return;
      end
      cyc();
    end
  endtask

  // Called on the cycle period_start is seen; walks one full period (phases 0..254).
  task automatic measure(output int hi, output int ps_mid, output bit ps_end, output int busy_lo);
    hi = 0; ps_mid = 0; ps_end = 0; busy_lo = 0;
    for (int j = 1; j <= PER; j++) begin
      cyc();
      if (pwm_out === 1'b1) hi++;
      if (busy !== 1'b1) busy_lo++;
      if (j < PER && period_start !== 1'b0) ps_mid++;
      if (j == PER) ps_end = (period_start === 1'b1);
    end
  endtask

  task automatic start_run(input int level);
    bit ok;
    lvl = LW'(level);
    en  = 1'b1;
    wait_ps(ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL start_ps: period_start not seen within bound (level %0d)", level);
    end
  endtask

  task automatic test_reset();
    logic [12:0] obs;
    rst = 1'b1; en = 1'b1; dir = 1'b1; lvl = 8'd77;
    repeat (3) cyc();
    obs = {pwm_out, period_start, duty_applied, peak_pulse, trough_pulse, busy};
    n_cmp++;
    if (obs !== 13'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want 0000", obs);
    end
    en = 1'b0; dir = 1'b0; rst = 1'b0;
    repeat (3) cyc();
    n_cmp++;
    if (busy !== 1'b0 || pwm_out !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_reset: busy=%b pwm=%b want 0 0", busy, pwm_out);
    end
  endtask

  task automatic test_dark();
    int hi, psm, blo;
    bit pse;
    start_run(0);
    for (int p = 0; p < 3; p++) begin
      measure(hi, psm, pse, blo);
      n_cmp++;
      if (hi != 0 || psm != 0 || !pse || blo != 0) begin
        n_err++;
        $display("FAIL dark_period%0d: high=%0d mid_ps=%0d end_ps=%b busy_low=%0d want 0 0 1 0",
                 p, hi, psm, pse, blo);
      end
    end
  endtask

  task automatic test_duty();
    int hi, psm, blo;
    bit pse;
    lvl = 8'd100;
    measure(hi, psm, pse, blo);       // period already latched at level 0
    n_cmp++;
    if (duty_applied !== 8'd100) begin
      n_err++;
      $display("FAIL duty100_applied: got %0d want 100", duty_applied);
    end
    measure(hi, psm, pse, blo);
    n_cmp++;
    if (hi != ref_duty(100) || !pse || psm != 0) begin
      n_err++;
      $display("FAIL duty100_high: got %0d end_ps=%b want %0d 1", hi, pse, ref_duty(100));
    end
    lvl = 8'd255;
    measure(hi, psm, pse, blo);
    hi = 0;
    for (int p = 0; p < 3; p++) begin
      int h;
      measure(h, psm, pse, blo);
      hi += h;
    end
    n_cmp++;
    if (hi != 3 * PER) begin
      n_err++;
      $display("FAIL full_on_3periods: high=%0d want %0d", hi, 3 * PER);
    end
  endtask

  task automatic test_mid_change();
    int hi, psm, blo;
    bit pse;
    logic [LW-1:0] d_before;
    lvl = 8'd100;
    measure(hi, psm, pse, blo);       // still 255 this period
    hi = 0;
    d_before = '0;
    for (int j = 1; j <= PER; j++) begin
      cyc();
      if (pwm_out === 1'b1) hi++;
      if (j == 40) lvl = 8'd200;
      if (j == PER - 1) d_before = duty_applied;
    end
    n_cmp++;
    if (hi != ref_duty(100) || d_before !== LW'(ref_duty(100))) begin
      n_err++;
      $display("FAIL midchange_old: high=%0d duty=%0d want %0d", hi, d_before, ref_duty(100));
    end
    n_cmp++;
    if (period_start !== 1'b1 || duty_applied !== LW'(ref_duty(200))) begin
      n_err++;
      $display("FAIL midchange_latch: ps=%b duty=%0d want 1 %0d", period_start, duty_applied,
               ref_duty(200));
    end
    measure(hi, psm, pse, blo);
    n_cmp++;
    if (hi != ref_duty(200)) begin
      n_err++;
      $display("FAIL midchange_new: high=%0d want %0d", hi, ref_duty(200));
    end
  endtask

  task automatic test_drain();
    int hi, psm, blo, late;
    bit pse;
    bit b254, b255, ps255;
    lvl = 8'd100;
    measure(hi, psm, pse, blo);       // 200 period; now at a duty-100 period start
    hi = 0; blo = 0; late = 0; b254 = 0; b255 = 1; ps255 = 1;
    for (int j = 1; j <= PER + 5; j++) begin
      cyc();
      if (j <= PER && pwm_out === 1'b1) hi++;
      if (j < PER - 1 && busy !== 1'b1) blo++;
      if (j == 50) en = 1'b0;
      if (j == PER - 1) b254 = busy;
      if (j == PER) begin b255 = busy; ps255 = period_start; end
      if (j > PER && (busy !== 1'b0 || pwm_out !== 1'b0)) late++;
    end
    n_cmp++;
    if (hi != ref_duty(100) || blo != 0) begin
      n_err++;
      $display("FAIL drain_complete: high=%0d busy_low=%0d want %0d 0", hi, blo, ref_duty(100));
    end
    n_cmp++;
    if (b254 !== 1'b1 || b255 !== 1'b0 || ps255 !== 1'b0 || late != 0) begin
      n_err++;
      $display("FAIL drain_idle: busy254=%b busy255=%b ps255=%b late=%0d want 1 0 0 0",
               b254, b255, ps255, late);
    end
  endtask

  task automatic test_cancel_and_reset();
    int hi, psm, blo;
    bit pse;
    logic [12:0] obs;
    start_run(100);
    hi = 0; blo = 0;
    for (int j = 1; j <= PER; j++) begin
      cyc();
      if (pwm_out === 1'b1) hi++;
      if (busy !== 1'b1) blo++;
      if (j == 50) en = 1'b0;
      if (j == 200) en = 1'b1;
    end
    n_cmp++;
    if (hi != ref_duty(100) || blo != 0 || period_start !== 1'b1) begin
      n_err++;
      $display("FAIL drain_cancel: high=%0d busy_low=%0d ps=%b want %0d 0 1",
               hi, blo, period_start, ref_duty(100));
    end
    for (int j = 1; j <= 30; j++) cyc();
    rst = 1'b1;
    cyc();
    obs = {pwm_out, period_start, duty_applied, peak_pulse, trough_pulse, busy};
    n_cmp++;
    if (obs !== 13'h0) begin
      n_err++;
      $display("FAIL reset_mid_run: got %h want 0000", obs);
    end
    rst = 1'b0; en = 1'b0;
    cyc();
  endtask

  task automatic test_direction();
    repeat (3) cyc();
    dir = 1'b1;
    cyc();
    n_cmp++;
    if (peak_pulse !== 1'b1 || trough_pulse !== 1'b0) begin
      n_err++;
      $display("FAIL peak_edge: peak=%b trough=%b want 1 0", peak_pulse, trough_pulse);
    end
    cyc();
    n_cmp++;
    if (peak_pulse !== 1'b0 || trough_pulse !== 1'b0) begin
      n_err++;
      $display("FAIL peak_width: peak=%b trough=%b want 0 0", peak_pulse, trough_pulse);
    end
    repeat (2) cyc();
    dir = 1'b0;
    cyc();
    n_cmp++;
    if (trough_pulse !== 1'b1 || peak_pulse !== 1'b0) begin
      n_err++;
      $display("FAIL trough_edge: trough=%b peak=%b want 1 0", trough_pulse, peak_pulse);
    end
    cyc();
    n_cmp++;
    if (trough_pulse !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL trough_width: trough=%b busy=%b want 0 0", trough_pulse, busy);
    end
  endtask

  task automatic test_levels();
    int levels [4] = '{128, 0, 255, 1};
    int hi, psm, blo;
    bit pse;
    start_run(levels[0]);
    for (int k = 0; k < 4; k++) begin
      lvl = LW'(levels[k]);
      measure(hi, psm, pse, blo);
      measure(hi, psm, pse, blo);
      n_cmp++;
      if (hi != ref_duty(levels[k])) begin
        n_err++;
        $display("FAIL level%0d_high: got %0d want %0d", levels[k], hi, ref_duty(levels[k]));
      end
    end
    en = 1'b0;
    repeat (2 * PER) cyc();
  endtask

  task automatic test_random();
    logic [12:0] obs, exp_v;
    int bad = 0;
    for (int c = 0; c < 4000; c++) begin
      cyc();
      obs   = {pwm_out, period_start, duty_applied, peak_pulse, trough_pulse, busy};
      exp_v = {e_pwm, e_ps, LW'(m_duty), e_peak, e_trough, e_busy};
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++;
        bad++;
        if (bad <= 20)
          $display("FAIL random_cycle%0d: got %h want %h", c, obs, exp_v);
      end
      rst = 1'b0;
      if ($urandom_range(19, 0) == 0) lvl = LW'($urandom);
      if ($urandom_range(15, 0) == 0) dir = ~dir;
      if ($urandom_range(399, 0) == 0) en = ~en;
      if ($urandom_range(1999, 0) == 0) rst = 1'b1;
      if (c == 10) en = 1'b1;
    end
  endtask

  initial begin
    test_reset();
    test_dark();
    test_duty();
    test_mid_change();
    test_drain();
    test_cancel_and_reset();
    test_direction();
    test_levels();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
